mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU and loader/debug share one single-ported memory
// with a fixed number of wait states, round-robin arbitration and a loader lock.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_ready,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_wd,
  output logic [31:0] dbg_rd,
  output logic        dbg_ready,
  input  logic        dbg_lock,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_DBG  = 1'b1;
  localparam logic [2:0] CNT_LAST = 3'(WAIT);

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic       owner;
  logic       last_owner;
  logic       we_q;
  logic       grant_any;
  logic       grant_sel;
  logic       rd_capture;
  logic [1:0] owner_oh;

  // Lock only keeps ownership while the loader is actually asking; otherwise
  // plain round-robin against the previous owner.
  always_comb begin
    grant_any = cpu_req | dbg_req;
    if (dbg_lock && (last_owner == OWN_DBG) && dbg_req)
      grant_sel = OWN_DBG;
    else if (cpu_req && dbg_req)
      grant_sel = ~last_owner;
    else if (dbg_req)
      grant_sel = OWN_DBG;
    else
      grant_sel = OWN_CPU;
  end

  assign owner_oh = (owner == OWN_DBG) ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    gnt        = 2'b00;
    cpu_ready  = 1'b0;
    dbg_ready  = 1'b0;
    rd_capture = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any)
          state_nxt = BUSY;
      end
      BUSY: begin
        mem_en = 1'b1;
        mem_we = we_q;
        gnt    = owner_oh;
        if (cnt == CNT_LAST) begin
          rd_capture = ~we_q;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        gnt       = owner_oh;
        cpu_ready = (owner == OWN_CPU);
        dbg_ready = (owner == OWN_DBG);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_ready;

  // Request fields are latched only at grant, so requesters may change or drop
  // their inputs while the access is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 3'd0;
      last_owner <= OWN_DBG;
      owner      <= OWN_CPU;
      we_q       <= 1'b0;
      mem_adr    <= 32'd0;
      mem_wd     <= 32'd0;
      cpu_rd     <= 32'd0;
      dbg_rd     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (grant_any) begin
            owner   <= grant_sel;
            we_q    <= grant_sel ? dbg_we  : cpu_we;
            mem_adr <= grant_sel ? dbg_adr : cpu_adr;
            mem_wd  <= grant_sel ? dbg_wd  : cpu_wd;
          end
        end
        BUSY: begin
          cnt <= cnt + 3'd1;
          if (rd_capture) begin
            if (owner == OWN_DBG)
              dbg_rd <= mem_rd;
            else
              cpu_rd <= mem_rd;
          end
        end
        RESP: begin
          cnt        <= 3'd0;
          last_owner <= owner;
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

endmodule
